// File: rtl/lab3_codes_pkg.sv
// Shared code constants and bit-position encoding for the Lab 3 serial
// BCD <-> Excess-3 converters.
package lab3_codes_pkg;

    localparam logic [3:0] EXCESS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam int         WORD_BITS      = 4;

    typedef enum logic [1:0] {
        POS_B0 = 2'd0,
        POS_B1 = 2'd1,
        POS_B2 = 2'd2,
        POS_B3 = 2'd3
    } pos_t;

    // Subtrahend bit applied at a given serial position (0011, LSB first).
    function automatic logic offset_bit(input pos_t p);
        logic [3:0] w_off;
        w_off = EXCESS3_OFFSET;
        return w_off[p];
    endfunction

endpackage

// File: rtl/lab3_excess3_to_bcd.sv
// Serial Excess-3 to BCD decoder: LSB-first subtract-3 with borrow, Mealy z/err,
// sticky registered error flag.
module lab3_excess3_to_bcd
    import lab3_codes_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic x,
    output logic z,
    output logic last,
    output logic err,
    output logic err_seen
);

    pos_t       r_pos;
    logic       r_b;
    logic [2:0] r_d;
    logic       r_err_seen;

    pos_t       w_pos_next;
    logic       w_sub;
    logic       w_b_in;
    logic       w_borrow;
    logic       w_last;
    logic [2:0] w_d_next;

    always_comb begin
        w_sub      = offset_bit(r_pos);
        // Bit 0 never inherits a borrow, so a word is independent of its predecessor.
        w_b_in     = (r_pos == POS_B0) ? 1'b0 : r_b;
        z          = x ^ w_sub ^ w_b_in;
        w_borrow   = (~x & (w_sub | w_b_in)) | (w_sub & w_b_in);
        w_last     = (r_pos == POS_B3);
        w_pos_next = pos_t'(r_pos + 2'd1);
        w_d_next   = r_d;
        for (int i = 0; i < 3; i++) begin
            if (r_pos == 2'(i)) begin
                w_d_next[i] = z;
            end
        end
    end

    // Final borrow means code < 3; z with d[2] or d[1] set means decoded digit > 9.
    assign last     = w_last;
    assign err      = w_last & (w_borrow | (z & (r_d[2] | r_d[1])));
    assign err_seen = r_err_seen;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pos      <= POS_B0;
            r_b        <= 1'b0;
            r_d        <= 3'b000;
            r_err_seen <= 1'b0;
        end else begin
            r_pos      <= w_pos_next;
            r_err_seen <= r_err_seen | err;
            if (w_last) begin
                r_b <= 1'b0;
                r_d <= 3'b000;
            end else begin
                r_b <= w_borrow;
                r_d <= w_d_next;
            end
        end
    end

endmodule
